// File: rtl/i2c_slave_pkg.sv
// ============================================================================
//  Module   : i2c_slave_pkg
//  Purpose  : Shared I2C definitions: FSM state encoding, bus widths and the
//             ACK/NACK bit levels.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package i2c_slave_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    // Level of the acknowledge bit on the bus.
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX        = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX        = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_slave_if.sv
// ============================================================================
//  Module   : i2c_slave_if
//  Purpose  : Groups the I2C pin signals and the fabric byte handshake of the
//             I2C target.
//  Signals  : scl_in, sda_in   pin levels (asynchronous)
//             sda_oe           1 = pull SDA low
//             rx_data/rx_valid received write byte and its one-clk strobe
//             tx_data/tx_req   read byte and its one-clk request strobe
//             busy             transfer addressed to this target in progress
//  Modports : slave  - the I2C target side
//             master - the board/fabric side driving the target
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface i2c_slave_if;
    import i2c_slave_pkg::*;

    logic                  scl_in;
    logic                  sda_in;
    logic                  sda_oe;
    logic [I2C_BYTE_W-1:0] rx_data;
    logic                  rx_valid;
    logic [I2C_BYTE_W-1:0] tx_data;
    logic                  tx_req;
    logic                  busy;

    modport slave (
        input  scl_in, sda_in, tx_data,
        output sda_oe, rx_data, rx_valid, tx_req, busy
    );

    modport master (
        output scl_in, sda_in, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_req, busy
    );

endinterface

`default_nettype wire

// File: rtl/i2c_sync_edge.sv
// ============================================================================
//  Module   : i2c_sync_edge
//  Purpose  : Multi-flop synchroniser for an asynchronous pin followed by a
//             one-flop edge detector producing single-clk rise/fall strobes.
//  Ports    : clk      in  system clock
//             reset    in  synchronous active-high reset
//             din_i    in  asynchronous pin level
//             level_o  out synchronised level
//             rise_o   out one-clk strobe on a 0->1 transition
//             fall_o   out one-clk strobe on a 1->0 transition
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Reset to the idle-bus level so leaving reset on a quiet bus creates
    // no spurious edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

`default_nettype wire

// File: rtl/i2c_slave.sv
// ============================================================================
//  Module   : i2c_slave
//  Purpose  : I2C target. Oversamples SCL/SDA, detects START/STOP, matches a
//             7-bit address and ACKs it; receives write bytes into the fabric
//             and shifts read bytes fetched from the fabric out MSB first.
//  Ports    : clk    in  system clock (>= 8x SCL)
//             reset  in  synchronous active-high reset
//             bus    i2c_slave_if.slave (pins and fabric byte handshake)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    i2c_slave_if.slave bus
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk     (clk),
        .reset   (reset),
        .din_i   (bus.scl_in),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk     (clk),
        .reset   (reset),
        .din_i   (bus.sda_in),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [I2C_BYTE_W-1:0] shreg_q, shreg_d;
    logic                  rw_q, rw_d;
    // Second-step marker inside the multi-fall states: in ADDR_ACK it means
    // the ACK is being driven, in RX the byte is complete, in TX_ACK the
    // master ACKed and the next byte loads on the coming fall.
    logic                  phase_q, phase_d;
    logic                  sda_oe_q, sda_oe_d;
    logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tx_req_q, tx_req_d;
    logic                  busy_q, busy_d;

    logic                  start_evt, stop_evt;
    logic [I2C_BYTE_W-1:0] byte_in;

    assign start_evt = sda_fall & scl_lvl;
    assign stop_evt  = sda_rise & scl_lvl;
    // Shift register contents after taking in the bit present on SDA now.
    assign byte_in   = {shreg_q[I2C_BYTE_W-2:0], sda_lvl};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd7;
            shreg_q    <= '0;
            rw_q       <= 1'b0;
            phase_q    <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        rw_d       = rw_q;
        phase_d    = phase_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;

        if (start_evt) begin
            // Also covers repeated START: any partial byte is abandoned.
            state_d  = ST_ADDR;
            cnt_d    = 3'd7;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            phase_d  = 1'b0;
        end else if (stop_evt) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            phase_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shreg_d = byte_in;
                        if (cnt_q == 3'd0) begin
                            if (byte_in[7:1] == SLAVE_ADDR) begin
                                state_d  = ST_ADDR_ACK;
                                busy_d   = 1'b1;
                                rw_d     = byte_in[0];
                                tx_req_d = byte_in[0];
                                phase_d  = 1'b0;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = ~ACK;
                            phase_d  = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            cnt_d   = 3'd7;
                            if (rw_q) begin
                                shreg_d  = bus.tx_data;
                                sda_oe_d = ~bus.tx_data[7];
                                state_d  = ST_TX;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = ST_RX;
                            end
                        end
                    end
                end

                ST_RX: begin
                    if (scl_rise) begin
                        shreg_d = byte_in;
                        if (cnt_q == 3'd0) begin
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            phase_d    = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end else if (scl_fall && phase_q) begin
                        sda_oe_d = ~ACK;
                        phase_d  = 1'b0;
                        state_d  = ST_RX_ACK;
                    end
                end

                ST_RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 3'd7;
                        state_d  = ST_RX;
                    end
                end

                ST_TX: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            phase_d  = 1'b0;
                            state_d  = ST_TX_ACK;
                        end else begin
                            // Rotate so the next bit to drive sits at [7].
                            shreg_d  = {shreg_q[I2C_BYTE_W-2:0], shreg_q[I2C_BYTE_W-1]};
                            sda_oe_d = ~shreg_q[I2C_BYTE_W-2];
                            cnt_d    = cnt_q - 3'd1;
                        end
                    end
                end

                ST_TX_ACK: begin
                    if (scl_rise && !phase_q) begin
                        if (sda_lvl == NACK) begin
                            state_d = ST_WAIT_STOP;
                        end else begin
                            tx_req_d = 1'b1;
                            phase_d  = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        shreg_d  = bus.tx_data;
                        sda_oe_d = ~bus.tx_data[7];
                        cnt_d    = 3'd7;
                        phase_d  = 1'b0;
                        state_d  = ST_TX;
                    end
                end

                default: begin
                    // IDLE and WAIT_STOP only react to START/STOP.
                end
            endcase
        end
    end

    assign bus.sda_oe   = sda_oe_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_req   = tx_req_q;
    assign bus.busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave.sv
// ============================================================================
//  Module   : tb_i2c_slave
//  Purpose  : Self-checking bench for i2c_slave. Models the bus master and
//             the SDA pull-up (pin = ~sda_oe & master_sda), SCL = clk/16.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_i2c_slave;

    typedef struct {
        logic [7:0]      addr;
        int              nbytes;
        logic [1:0][7:0] data;
        logic            exp_nack;   // expected SDA level on every ACK bit
        logic            exp_busy;
        int              exp_rx;
    } wr_vec_t;

    logic clk;
    logic rst;
    logic m_sda;

    int checks   = 0;
    int failures = 0;

    int         rx_cnt = 0;
    logic [7:0] rx_log [0:63];
    int         tx_cnt = 0;
    logic [7:0] c_tx [0:3] = '{8'h96, 8'h0F, 8'h3C, 8'h5A};

    i2c_slave_if bus_if ();

    assign bus_if.sda_in = ~bus_if.sda_oe & m_sda;

    i2c_slave #(
        .SLAVE_ADDR  (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every received byte.
    always @(negedge clk) begin
        if (bus_if.rx_valid) begin
            rx_log[rx_cnt[5:0]] = bus_if.rx_data;
            rx_cnt = rx_cnt + 1;
        end
    end

    // Fabric read-data responder: next byte from c_tx on each tx_req.
    always @(negedge clk) begin
        if (rst) begin
            bus_if.tx_data = 8'h00;
        end else if (bus_if.tx_req) begin
            bus_if.tx_data = c_tx[tx_cnt[1:0]];
            tx_cnt = tx_cnt + 1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period; SDA is set at the start of the low phase and the pin
    // is sampled in the middle of the high phase.
    task automatic send_bit(input logic b, output logic seen);
        m_sda = b;
        tick(4);
        bus_if.scl_in = 1'b1;
        tick(4);
        seen = bus_if.sda_in;
        tick(4);
        bus_if.scl_in = 1'b0;
        tick(4);
    endtask

    task automatic i2c_start();
        if (bus_if.scl_in) begin
            m_sda = 1'b0;
            tick(8);
            bus_if.scl_in = 1'b0;
            tick(4);
        end else begin
            m_sda = 1'b1;
            tick(4);
            bus_if.scl_in = 1'b1;
            tick(4);
            m_sda = 1'b0;
            tick(4);
            bus_if.scl_in = 1'b0;
            tick(4);
        end
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0;
        tick(4);
        bus_if.scl_in = 1'b1;
        tick(4);
        m_sda = 1'b1;
        tick(8);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack_pin);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, ack_pin);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            b[i] = s;
        end
        send_bit(nack, s);
    endtask

    function automatic wr_vec_t mk(input logic [7:0] addr, input int n,
                                   input logic [7:0] d0, input logic [7:0] d1,
                                   input logic nack, input logic bsy, input int rx);
        wr_vec_t v;
        v.addr     = addr;
        v.nbytes   = n;
        v.data[0]  = d0;
        v.data[1]  = d1;
        v.exp_nack = nack;
        v.exp_busy = bsy;
        v.exp_rx   = rx;
        return v;
    endfunction

    wr_vec_t    vecs [0:4];
    logic       ack;
    logic [7:0] rd;
    int         rx_base;
    int         tx_base;

    initial begin
        vecs[0] = mk(8'hA0, 1, 8'h00, 8'h00, 1'b0, 1'b1, 1);
        vecs[1] = mk(8'hA0, 1, 8'hFF, 8'h00, 1'b0, 1'b1, 1);
        vecs[2] = mk(8'h50, 1, 8'h55, 8'h00, 1'b1, 1'b0, 0);
        vecs[3] = mk(8'hA0, 2, 8'hA5, 8'h3C, 1'b0, 1'b1, 2);
        vecs[4] = mk(8'hA2, 1, 8'hA2, 8'h00, 1'b1, 1'b0, 0);

        rst           = 1'b1;
        m_sda         = 1'b1;
        bus_if.scl_in = 1'b1;
        tick(5);
        check("rst_sda_oe",   {31'd0, bus_if.sda_oe},   32'd0);
        check("rst_rx_valid", {31'd0, bus_if.rx_valid}, 32'd0);
        check("rst_tx_req",   {31'd0, bus_if.tx_req},   32'd0);
        check("rst_busy",     {31'd0, bus_if.busy},     32'd0);
        check("rst_rx_data",  {24'd0, bus_if.rx_data},  32'd0);
        rst = 1'b0;
        tick(6);

        // Write transfers
        for (int k = 0; k < 5; k++) begin
            rx_base = rx_cnt;
            i2c_start();
            write_byte(vecs[k].addr, ack);
            check("addr_ack", {31'd0, ack}, {31'd0, vecs[k].exp_nack});
            check("busy_addr", {31'd0, bus_if.busy}, {31'd0, vecs[k].exp_busy});
            for (int j = 0; j < vecs[k].nbytes; j++) begin
                write_byte(vecs[k].data[j], ack);
                check("data_ack", {31'd0, ack}, {31'd0, vecs[k].exp_nack});
            end
            i2c_stop();
            tick(4);
            check("rx_count", rx_cnt - rx_base, vecs[k].exp_rx);
            for (int j = 0; j < vecs[k].exp_rx; j++)
                check("rx_data", {24'd0, rx_log[(rx_base + j) % 64]}, {24'd0, vecs[k].data[j]});
            check("busy_stop", {31'd0, bus_if.busy}, 32'd0);
        end
        check("rx_data_hold", {24'd0, bus_if.rx_data}, 32'h3C);

        // Read 0x96 (ACK) then 0x0F (NACK)
        tx_base = tx_cnt;
        i2c_start();
        write_byte(8'hA1, ack);
        check("rd_addr_ack", {31'd0, ack}, 32'd0);
        check("rd_busy", {31'd0, bus_if.busy}, 32'd1);
        check("rd_txreq1", tx_cnt - tx_base, 1);
        read_byte(1'b0, rd);
        check("rd_byte0", {24'd0, rd}, 32'h96);
        read_byte(1'b1, rd);
        check("rd_byte1", {24'd0, rd}, 32'h0F);
        tick(2);
        check("rd_nack_release", {31'd0, bus_if.sda_oe}, 32'd0);
        check("rd_txreq2", tx_cnt - tx_base, 2);
        i2c_stop();
        tick(4);
        check("rd_busy_stop", {31'd0, bus_if.busy}, 32'd0);

        // Repeated START after 4 bits of a write byte, then read
        rx_base = rx_cnt;
        tx_base = tx_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        check("rs_wr_ack", {31'd0, ack}, 32'd0);
        send_bit(1'b1, ack);
        send_bit(1'b0, ack);
        send_bit(1'b1, ack);
        send_bit(1'b0, ack);
        i2c_start();
        write_byte(8'hA1, ack);
        check("rs_rd_ack", {31'd0, ack}, 32'd0);
        check("rs_no_rx", rx_cnt - rx_base, 0);
        check("rs_txreq", tx_cnt - tx_base, 1);
        read_byte(1'b1, rd);
        check("rs_rd_byte", {24'd0, rd}, 32'h3C);
        i2c_stop();
        tick(4);

        // STOP mid-byte in RX
        rx_base = rx_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        check("sp_wr_ack", {31'd0, ack}, 32'd0);
        send_bit(1'b0, ack);
        send_bit(1'b1, ack);
        send_bit(1'b1, ack);
        send_bit(1'b0, ack);
        i2c_stop();
        tick(4);
        check("sp_no_rx", rx_cnt - rx_base, 0);
        check("sp_busy", {31'd0, bus_if.busy}, 32'd0);

        // Reset while the target drives a 0 bit (0x5A, bit7 = 0)
        i2c_start();
        write_byte(8'hA1, ack);
        check("rr_addr_ack", {31'd0, ack}, 32'd0);
        tick(2);
        check("rr_drive0", {31'd0, bus_if.sda_oe}, 32'd1);
        check("rr_busy", {31'd0, bus_if.busy}, 32'd1);
        rst = 1'b1;
        tick(1);
        check("rr_sda_oe",   {31'd0, bus_if.sda_oe},   32'd0);
        check("rr_busy0",    {31'd0, bus_if.busy},     32'd0);
        check("rr_rx_valid", {31'd0, bus_if.rx_valid}, 32'd0);
        check("rr_tx_req",   {31'd0, bus_if.tx_req},   32'd0);
        check("rr_rx_data",  {24'd0, bus_if.rx_data},  32'd0);
        rst = 1'b0;
        m_sda = 1'b1;
        bus_if.scl_in = 1'b1;
        tick(10);
        check("rr_idle_oe", {31'd0, bus_if.sda_oe}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
